// File: rtl/rv32i_instr_encoder_if.sv
// Request and instruction-memory write bus for the RV32I encoder.
// The encoder takes the slave side; the requester and memory take the master side.
interface rv32i_instr_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            in_fmt;
    logic [6:0]            in_opcode;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs1;
    logic [4:0]            in_rs2;
    logic [2:0]            in_funct3;
    logic [6:0]            in_funct7;
    logic [31:0]           in_imm;
    logic                  imem_we;
    logic                  imem_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_valid, in_fmt, in_opcode,
        output in_rd, in_rs1, in_rs2,
        output in_funct3, in_funct7, in_imm,
        output imem_ready,
        input  in_ready, imem_we,
        input  imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_fmt, in_opcode,
        input  in_rd, in_rs1, in_rs2,
        input  in_funct3, in_funct7, in_imm,
        input  imem_ready,
        output in_ready, imem_we,
        output imem_addr, imem_wdata
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// Packs field-level RV32I requests into instruction words and
// streams them into instruction memory, rejecting malformed requests.
module rv32i_instr_encoder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    rv32i_instr_encoder_if.slave  bus,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic                  err_illegal,
    output logic [7:0]            err_count,
    output logic                  full
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_FULL
    } state_t;

    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;
    localparam logic [2:0] F_NONE = 3'd7;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic [31:0]           enc;
    logic [31:0]           imm;
    logic [2:0]            fmt_need;
    logic                  legal, imm_ok;
    logic                  accept, commit, last;

    assign imm    = bus.in_imm;
    assign last   = (addr == {ADDR_WIDTH{1'b1}});
    assign accept = bus.in_valid && bus.in_ready;
    assign commit = (state == S_WRITE) && bus.imem_ready;

    // Required format for each supported major opcode.
    always_comb begin
        fmt_need = F_NONE;
        case (bus.in_opcode)
            7'b0110011: fmt_need = F_R;
            7'b0010011: fmt_need = F_I;
            7'b0000011: fmt_need = F_I;
            7'b1100111: fmt_need = F_I;
            7'b0100011: fmt_need = F_S;
            7'b1100011: fmt_need = F_B;
            7'b0110111: fmt_need = F_U;
            7'b0010111: fmt_need = F_U;
            7'b1101111: fmt_need = F_J;
            default:    fmt_need = F_NONE;
        endcase
    end

    // Immediate representability for the requested format.
    always_comb begin
        imm_ok = 1'b0;
        case (bus.in_fmt)
            F_R: imm_ok = 1'b1;
            F_I, F_S:
                imm_ok = (&imm[31:11]) || !(|imm[31:11]);
            F_B:
                imm_ok = ((&imm[31:12]) || !(|imm[31:12]))
                         && !imm[0];
            F_J:
                imm_ok = ((&imm[31:20]) || !(|imm[31:20]))
                         && !imm[0];
            F_U: imm_ok = !(|imm[11:0]);
            default: imm_ok = 1'b0;
        endcase
        legal = imm_ok && (fmt_need != F_NONE)
                && (fmt_need == bus.in_fmt);
    end

    // Field packing per instruction format.
    always_comb begin
        enc = 32'h0;
        case (bus.in_fmt)
            F_R: enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_rd, bus.in_opcode};
            F_I: enc = {imm[11:0], bus.in_rs1,
                        bus.in_funct3, bus.in_rd, bus.in_opcode};
            F_S: enc = {imm[11:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, imm[4:0], bus.in_opcode};
            F_B: enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, imm[4:1], imm[11],
                        bus.in_opcode};
            F_U: enc = {imm[31:12], bus.in_rd, bus.in_opcode};
            F_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12],
                        bus.in_rd, bus.in_opcode};
            default: enc = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state: clear wins, a write at the top address parks in FULL.
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:
                    if (accept && legal) state_nx = S_WRITE;
                S_WRITE:
                    if (commit) begin
                        if (last)                state_nx = S_FULL;
                        else if (accept && legal) state_nx = S_WRITE;
                        else                      state_nx = S_IDLE;
                    end
                S_FULL:  state_nx = S_FULL;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Outputs; the final commit refuses a new request so it is not lost.
    always_comb begin
        bus.imem_we  = (state == S_WRITE);
        full         = (state == S_FULL);
        bus.in_ready = rst_n && !clear &&
                       ((state == S_IDLE) ||
                        ((state == S_WRITE) && bus.imem_ready && !last));
    end

    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;

    // Address, holding register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= '0;
            wdata         <= 32'h0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_count     <= 8'h0;
        end else if (clear) begin
            addr          <= '0;
            words_written <= '0;
            err_illegal   <= 1'b0;
            err_count     <= 8'h0;
        end else begin
            if (commit) begin
                words_written <= words_written + (ADDR_WIDTH+1)'(1);
                if (!last) addr <= addr + ADDR_WIDTH'(1);
            end
            if (accept && legal) wdata <= enc;
            if (accept && !legal) begin
                err_illegal <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed vector bench for rv32i_instr_encoder.
// A wide instance covers encoding and errors; a 4-word one covers FULL.
module tb_rv32i_instr_encoder;
    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } req_t;

    typedef struct {
        req_t        r;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_b = 1'b0;
    logic clr_s = 1'b0;

    logic [8:0] ww_b;
    logic       ei_b;
    logic [7:0] ec_b;
    logic       full_b;
    logic [2:0] ww_s;
    logic       ei_s;
    logic [7:0] ec_s;
    logic       full_s;

    int n_cmp = 0;
    int n_err = 0;

    rv32i_instr_encoder_if #(.ADDR_WIDTH(8)) bb ();
    rv32i_instr_encoder_if #(.ADDR_WIDTH(2)) sb ();

    rv32i_instr_encoder #(.ADDR_WIDTH(8)) u_big (
        .clk(clk), .rst_n(rst_n), .clear(clr_b), .bus(bb.slave),
        .words_written(ww_b), .err_illegal(ei_b),
        .err_count(ec_b), .full(full_b)
    );

    rv32i_instr_encoder #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .rst_n(rst_n), .clear(clr_s), .bus(sb.slave),
        .words_written(ww_s), .err_illegal(ei_s),
        .err_count(ec_s), .full(full_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic req_t mk(input logic [2:0] fmt,
                                input logic [6:0] opc,
                                input logic [4:0] rd,
                                input logic [4:0] rs1,
                                input logic [4:0] rs2,
                                input logic [2:0] f3,
                                input logic [6:0] f7,
                                input logic [31:0] imm);
        req_t r;
        r.fmt = fmt; r.opc = opc; r.rd = rd; r.rs1 = rs1;
        r.rs2 = rs2; r.f3 = f3; r.f7 = f7; r.imm = imm;
        return r;
    endfunction

    task automatic drv_b(input req_t r, input logic v);
        bb.in_valid = v; bb.in_fmt = r.fmt; bb.in_opcode = r.opc;
        bb.in_rd = r.rd; bb.in_rs1 = r.rs1; bb.in_rs2 = r.rs2;
        bb.in_funct3 = r.f3; bb.in_funct7 = r.f7; bb.in_imm = r.imm;
    endtask

    task automatic drv_s(input req_t r, input logic v);
        sb.in_valid = v; sb.in_fmt = r.fmt; sb.in_opcode = r.opc;
        sb.in_rd = r.rd; sb.in_rs1 = r.rs1; sb.in_rs2 = r.rs2;
        sb.in_funct3 = r.f3; sb.in_funct7 = r.f7; sb.in_imm = r.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_big_reset(input string tag);
        chk({tag, " we"},    32'(bb.imem_we), 32'd0);
        chk({tag, " addr"},  32'(bb.imem_addr), 32'd0);
        chk({tag, " wdata"}, bb.imem_wdata, 32'd0);
        chk({tag, " words"}, 32'(ww_b), 32'd0);
        chk({tag, " eill"},  32'(ei_b), 32'd0);
        chk({tag, " ecnt"},  32'(ec_b), 32'd0);
        chk({tag, " full"},  32'(full_b), 32'd0);
        chk({tag, " rdy"},   32'(bb.in_ready), 32'd0);
    endtask

    vec_t vt[17];
    req_t ra, rb, rz;
    logic [31:0] sw[5];

    initial begin
        int exp_addr;
        int exp_err;

        rz = mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        // fmt opc rd rs1 rs2 f3 f7 imm ; legal ; word
        vt[0]  = '{mk(1, 7'b0010011, 1, 0, 0, 0, 0, 5),
                   1, 32'h00500093};
        vt[1]  = '{mk(0, 7'b0110011, 3, 1, 2, 0, 0, 0),
                   1, 32'h002081B3};
        vt[2]  = '{mk(2, 7'b0100011, 0, 1, 2, 2, 0, 8),
                   1, 32'h0020A423};
        vt[3]  = '{mk(3, 7'b1100011, 0, 1, 2, 0, 0, -4),
                   1, 32'hFE208EE3};
        vt[4]  = '{mk(5, 7'b1101111, 1, 0, 0, 0, 0, 8),
                   1, 32'h008000EF};
        vt[5]  = '{mk(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h12345000),
                   1, 32'h123452B7};
        vt[6]  = '{mk(1, 7'b1110011, 1, 0, 0, 0, 0, 0),
                   0, 32'h0};
        vt[7]  = '{mk(1, 7'b0010011, 1, 0, 0, 0, 0, 2048),
                   0, 32'h0};
        vt[8]  = '{mk(3, 7'b1100011, 0, 1, 2, 0, 0, 6),
                   1, 32'h00208363};
        vt[9]  = '{mk(3, 7'b1100011, 0, 1, 2, 0, 0, 7),
                   0, 32'h0};
        vt[10] = '{mk(4, 7'b0110111, 5, 0, 0, 0, 0, 32'h123),
                   0, 32'h0};
        vt[11] = '{mk(1, 7'b0110011, 3, 1, 2, 0, 0, 0),
                   0, 32'h0};
        vt[12] = '{mk(6, 7'b0010011, 1, 0, 0, 0, 0, 0),
                   0, 32'h0};
        vt[13] = '{mk(1, 7'b0010011, 1, 0, 0, 0, 0, -2048),
                   1, 32'h80000093};
        vt[14] = '{mk(2, 7'b0100011, 0, 1, 2, 2, 0, 2047),
                   1, 32'h7E20AFA3};
        vt[15] = '{mk(5, 7'b1101111, 1, 0, 0, 0, 0, 32'h100000),
                   0, 32'h0};
        vt[16] = '{mk(5, 7'b1101111, 0, 0, 0, 0, 0, -2),
                   1, 32'hFFFFF06F};
        ra = vt[0].r;
        rb = vt[1].r;
        sw = '{32'h00100093, 32'h00200093, 32'h00300093,
               32'h00400093, 32'h00500093};

        bb.imem_ready = 1'b1;
        sb.imem_ready = 1'b1;
        drv_b(rz, 1'b0);
        drv_s(rz, 1'b0);

        #2;
        chk_big_reset("rst");
        chk("rst s_full", 32'(full_s), 32'd0);
        #5 rst_n = 1'b1;
        @(negedge clk);

        // Table: back-to-back legal words mixed with rejected requests.
        exp_addr = 0;
        exp_err  = 0;
        for (int i = 0; i < 17; i++) begin
            drv_b(vt[i].r, 1'b1);
            #1;
            chk($sformatf("v%0d rdy", i), 32'(bb.in_ready), 32'd1);
            tick();
            chk($sformatf("v%0d words", i), 32'(ww_b), exp_addr);
            if (vt[i].legal) begin
                chk($sformatf("v%0d we", i), 32'(bb.imem_we), 32'd1);
                chk($sformatf("v%0d addr", i),
                    32'(bb.imem_addr), exp_addr);
                chk($sformatf("v%0d wdata", i),
                    bb.imem_wdata, vt[i].word);
                exp_addr++;
            end else begin
                exp_err++;
                chk($sformatf("v%0d we", i), 32'(bb.imem_we), 32'd0);
                chk($sformatf("v%0d addr", i),
                    32'(bb.imem_addr), exp_addr);
                chk($sformatf("v%0d eill", i), 32'(ei_b), 32'd1);
                chk($sformatf("v%0d ecnt", i), 32'(ec_b), exp_err);
            end
        end
        drv_b(rz, 1'b0);
        tick();
        chk("drain we", 32'(bb.imem_we), 32'd0);
        chk("drain words", 32'(ww_b), 32'd10);
        chk("drain addr", 32'(bb.imem_addr), 32'd10);
        chk("drain ecnt", 32'(ec_b), 32'd7);

        // Memory stall with a second request waiting.
        bb.imem_ready = 1'b0;
        drv_b(ra, 1'b1);
        tick();
        chk("stl we", 32'(bb.imem_we), 32'd1);
        drv_b(rb, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stl%0d rdy", i), 32'(bb.in_ready), 32'd0);
            chk($sformatf("stl%0d addr", i),
                32'(bb.imem_addr), 32'd10);
            chk($sformatf("stl%0d wdata", i),
                bb.imem_wdata, 32'h00500093);
            chk($sformatf("stl%0d we", i), 32'(bb.imem_we), 32'd1);
            tick();
        end
        chk("stl words", 32'(ww_b), 32'd10);
        bb.imem_ready = 1'b1;
        #1;
        chk("unstl rdy", 32'(bb.in_ready), 32'd1);
        tick();
        chk("unstl addr", 32'(bb.imem_addr), 32'd11);
        chk("unstl wdata", bb.imem_wdata, 32'h002081B3);
        chk("unstl words", 32'(ww_b), 32'd11);
        drv_b(rz, 1'b0);
        tick();
        chk("unstl2 words", 32'(ww_b), 32'd12);
        chk("unstl2 we", 32'(bb.imem_we), 32'd0);

        // clear while a stalled write is pending.
        bb.imem_ready = 1'b0;
        drv_b(ra, 1'b1);
        tick();
        chk("clr pre we", 32'(bb.imem_we), 32'd1);
        drv_b(rz, 1'b0);
        clr_b = 1'b1;
        #1;
        chk("clr rdy", 32'(bb.in_ready), 32'd0);
        tick();
        clr_b = 1'b0;
        chk("clr we", 32'(bb.imem_we), 32'd0);
        chk("clr words", 32'(ww_b), 32'd0);
        chk("clr addr", 32'(bb.imem_addr), 32'd0);
        chk("clr ecnt", 32'(ec_b), 32'd0);
        chk("clr eill", 32'(ei_b), 32'd0);

        // Async reset in the middle of a write stream.
        bb.imem_ready = 1'b1;
        drv_b(ra, 1'b1);
        tick();
        drv_b(rb, 1'b1);
        tick();
        chk("ar pre words", 32'(ww_b), 32'd1);
        chk("ar pre we", 32'(bb.imem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_big_reset("ar");
        drv_b(rz, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar post we", 32'(bb.imem_we), 32'd0);
        chk("ar post rdy", 32'(bb.in_ready), 32'd1);

        // 4-word memory: fill, block the 5th, clear, then accept it.
        for (int k = 0; k < 4; k++) begin
            drv_s(mk(1, 7'b0010011, 1, 0, 0, 0, 0, k + 1), 1'b1);
            #1;
            chk($sformatf("s%0d rdy", k), 32'(sb.in_ready), 32'd1);
            tick();
            chk($sformatf("s%0d we", k), 32'(sb.imem_we), 32'd1);
            chk($sformatf("s%0d addr", k), 32'(sb.imem_addr), k);
            chk($sformatf("s%0d wdata", k), sb.imem_wdata, sw[k]);
        end
        drv_s(mk(1, 7'b0010011, 1, 0, 0, 0, 0, 5), 1'b1);
        #1;
        chk("s4 rdy last", 32'(sb.in_ready), 32'd0);
        tick();
        chk("sf full", 32'(full_s), 32'd1);
        chk("sf words", 32'(ww_s), 32'd4);
        chk("sf we", 32'(sb.imem_we), 32'd0);
        chk("sf addr", 32'(sb.imem_addr), 32'd3);
        chk("sf rdy", 32'(sb.in_ready), 32'd0);
        tick();
        chk("sf2 full", 32'(full_s), 32'd1);
        chk("sf2 rdy", 32'(sb.in_ready), 32'd0);
        chk("sf2 words", 32'(ww_s), 32'd4);
        clr_s = 1'b1;
        tick();
        clr_s = 1'b0;
        #1;
        chk("sc full", 32'(full_s), 32'd0);
        chk("sc addr", 32'(sb.imem_addr), 32'd0);
        chk("sc words", 32'(ww_s), 32'd0);
        chk("sc rdy", 32'(sb.in_ready), 32'd1);
        tick();
        chk("s5 we", 32'(sb.imem_we), 32'd1);
        chk("s5 addr", 32'(sb.imem_addr), 32'd0);
        chk("s5 wdata", sb.imem_wdata, sw[4]);
        drv_s(rz, 1'b0);
        tick();
        chk("s5 words", 32'(ww_s), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
